// File: rtl/pid_controller_mc_if.sv
// pid_controller_mc_if: tick/config/duty bundle between the control sequencer and the PID core.
interface pid_controller_mc_if #(parameter int N_CH = 6, parameter int DW = 24);
  logic update;
  logic [N_CH-1:0] ch_en;
  logic [N_CH*DW-1:0] state_in;
  logic cfg_we;
  logic [3:0] cfg_ch;
  logic [2:0] cfg_addr;
  logic [DW-1:0] cfg_data;
  logic busy;
  logic done;
  logic [N_CH*DW-1:0] duty_out;
  modport master (output update, ch_en, state_in, cfg_we, cfg_ch, cfg_addr, cfg_data,
                  input busy, done, duty_out);
  modport slave (input update, ch_en, state_in, cfg_we, cfg_ch, cfg_addr, cfg_data,
                 output busy, done, duty_out);
endinterface

// File: rtl/pid_controller_mc.sv
// pid_controller_mc: multi-channel PID with one shared multiplier, 4 cycles per channel.
// Define PID_DERIVATIVE_EN to add the Kd*(err - err_prev) term.
module pid_controller_mc #(
  parameter int N_CH = 6,
  parameter int DW = 24,
  parameter int SHIFT = 0
) (
  input logic CLK,
  input logic reset,
  pid_controller_mc_if.slave bus
);
  localparam int CW = N_CH > 1 ? $clog2(N_CH) : 1;
  localparam int AW = 2 * DW + 2;
  localparam logic signed [DW:0] MX = {2'b00, {(DW-1){1'b1}}};
  localparam logic signed [DW:0] MN = ~MX;
  typedef enum logic [2:0] {IDLE, ERR, P, I, D, DONE} state_t;
  state_t st;
  logic [CW-1:0] ch;
  logic signed [DW-1:0] cfg [7][N_CH];
  logic signed [DW-1:0] st_q [N_CH];
  logic signed [DW-1:0] integ [N_CH];
  logic signed [DW-1:0] duty [N_CH];
  logic [N_CH-1:0] en_q;
  logic signed [DW-1:0] err, kp, ki, pl, il, integ_n, e_sat, ma;
  logic signed [DW:0] e_raw, e_abs, isum, mb;
  logic signed [2*DW:0] prod;
  logic signed [AW-1:0] acc, acc_f, acc_s;
  logic dz;
`ifdef PID_DERIVATIVE_EN
  logic signed [DW-1:0] kd;
  logic signed [DW-1:0] eprev [N_CH];
  logic signed [DW:0] dd;
`endif
  function automatic logic signed [DW-1:0] clamp(input logic signed [AW-1:0] v,
                                                  input logic signed [DW-1:0] l);
    logic signed [AW-1:0] m, n;
    m = l[DW-1] ? '0 : AW'(l);
    n = -m;
    return v > m ? DW'(m) : v < n ? DW'(n) : DW'(v);
  endfunction
  always_comb begin
    e_raw = (DW+1)'(st_q[ch]) - (DW+1)'(cfg[0][ch]);
    e_sat = e_raw > MX ? MX[DW-1:0] : e_raw < MN ? MN[DW-1:0] : e_raw[DW-1:0];
    e_abs = e_sat[DW-1] ? -(DW+1)'(e_sat) : (DW+1)'(e_sat);
    isum = (DW+1)'(integ[ch]) + (DW+1)'(err);
`ifdef PID_DERIVATIVE_EN
    dd = (DW+1)'(err) - (DW+1)'(eprev[ch]);
    ma = st == P ? kp : st == I ? ki : kd;
    mb = st == P ? (DW+1)'(err) : st == I ? (DW+1)'(integ_n) : dd;
    prod = (2*DW+1)'(ma) * (2*DW+1)'(mb);
    acc_f = acc + (st == D ? AW'(prod) : '0);
`else
    ma = st == P ? kp : ki;
    mb = st == P ? (DW+1)'(err) : (DW+1)'(integ_n);
    prod = (2*DW+1)'(ma) * (2*DW+1)'(mb);
    acc_f = acc;
`endif
    acc_s = acc_f >>> SHIFT;
  end
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      for (int a = 0; a < 7; a++)
        for (int k = 0; k < N_CH; k++) cfg[a][k] <= '0;
    end else if (bus.cfg_we && 32'(bus.cfg_ch) < N_CH && bus.cfg_addr != 3'd7) begin
      cfg[bus.cfg_addr][bus.cfg_ch[CW-1:0]] <= bus.cfg_data;
    end
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      st <= IDLE;
      ch <= '0;
      en_q <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      {err, kp, ki, pl, il, integ_n, acc, dz} <= '0;
      for (int k = 0; k < N_CH; k++) begin
        st_q[k] <= '0;
        integ[k] <= '0;
        duty[k] <= '0;
      end
`ifdef PID_DERIVATIVE_EN
      kd <= '0;
      for (int k = 0; k < N_CH; k++) eprev[k] <= '0;
`endif
    end else begin
      case (st)
        IDLE: if (bus.update) begin
          st <= ERR;
          ch <= '0;
          bus.busy <= 1'b1;
          en_q <= bus.ch_en;
          for (int k = 0; k < N_CH; k++) st_q[k] <= bus.state_in[k*DW +: DW];
        end
        ERR: begin
          err <= e_sat;
          dz <= e_abs <= (DW+1)'(cfg[6][ch]);
          kp <= cfg[1][ch];
          ki <= cfg[2][ch];
          pl <= cfg[4][ch];
          il <= cfg[5][ch];
`ifdef PID_DERIVATIVE_EN
          kd <= cfg[3][ch];
`endif
          st <= P;
        end
        P: begin
          acc <= AW'(prod);
          integ_n <= clamp(AW'(isum), il);
          st <= I;
        end
        I: begin
          acc <= acc + AW'(prod);
          // deadband holds the integral; a disabled channel forgets it
          integ[ch] <= !en_q[ch] ? '0 : dz ? integ[ch] : integ_n;
          st <= D;
        end
        D: begin
          duty[ch] <= (en_q[ch] && !dz) ? clamp(acc_s, pl) : '0;
`ifdef PID_DERIVATIVE_EN
          eprev[ch] <= en_q[ch] ? err : '0;
`endif
          ch <= ch + 1'b1;
          bus.done <= ch == CW'(N_CH - 1);
          st <= ch == CW'(N_CH - 1) ? DONE : ERR;
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  for (genvar k = 0; k < N_CH; k++) begin : g_out
    assign bus.duty_out[k*DW +: DW] = duty[k];
  end
endmodule

// File: tb/tb_pid_controller_mc.sv
// tb_pid_controller_mc: directed ticks; expected duties queued at update, checked on done.
module tb_pid_controller_mc;
  localparam int N = 6;
  localparam int DW = 24;
  localparam int LAT = 4 * N + 1;
`ifdef PID_DERIVATIVE_EN
  localparam int D1 = 30, D2 = 60;
`else
  localparam int D1 = 0, D2 = 0;
`endif
  typedef struct {
    logic [N*DW-1:0] duty;
    int cyc;
    int id;
  } exp_t;
  logic clk = 0;
  logic reset = 1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int tid = 0;
  exp_t sb[$];
  pid_controller_mc_if #(.N_CH(N), .DW(DW)) intf();
  pid_controller_mc #(.N_CH(N), .DW(DW), .SHIFT(0)) dut (.CLK(clk), .reset(reset), .bus(intf));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    exp_t e;
    if (intf.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got=1 want=0 at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        checks += 2;
        if (intf.duty_out !== e.duty) begin
          errors++;
          $display("FAIL duty tick%0d got=%h want=%h", e.id, intf.duty_out, e.duty);
        end
        if (cyc - e.cyc != LAT) begin
          errors++;
          $display("FAIL latency tick%0d got=%0d want=%0d", e.id, cyc - e.cyc, LAT);
        end
      end
    end
  end
  function automatic logic [N*DW-1:0] vec(input int a0, input int a5);
    logic [N*DW-1:0] v;
    v = '0;
    v[0 +: DW] = DW'(a0);
    v[5*DW +: DW] = DW'(a5);
    return v;
  endfunction
  task automatic check1(input string nm, input logic [N*DW-1:0] got, input logic [N*DW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask
  task automatic do_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask
  task automatic wcfg(input int c, input int a, input int d);
    intf.cfg_we = 1;
    intf.cfg_ch = 4'(c);
    intf.cfg_addr = 3'(a);
    intf.cfg_data = DW'(d);
    @(posedge clk);
    #1 intf.cfg_we = 0;
  endtask
  task automatic tick(input int s0, input int s5, input logic [N-1:0] en,
                      input int e0, input int e5, input bit poke);
    exp_t e;
    intf.state_in = vec(s0, s5);
    intf.ch_en = en;
    intf.update = 1;
    e.duty = vec(e0, e5);
    e.cyc = cyc;
    e.id = tid++;
    sb.push_back(e);
    @(posedge clk);
    #1 intf.update = 0;
    if (poke) begin
      repeat (3) @(posedge clk);
      #1 check1("busy_mid_tick", {{(N*DW-1){1'b0}}, intf.busy}, 1);
      intf.state_in = vec(999, 999);
      intf.update = 1;
      @(posedge clk);
      #1 intf.update = 0;
      repeat (4 * N) @(posedge clk);
    end else repeat (4 * N + 4) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout tick%0d got=none want=done", e.id);
      sb.delete();
    end
  endtask
  initial begin
    int t4 [5] = '{100, 200, 250, 250, 250};
    intf.update = 0;
    intf.ch_en = '0;
    intf.state_in = '0;
    intf.cfg_we = 0;
    intf.cfg_ch = '0;
    intf.cfg_addr = '0;
    intf.cfg_data = '0;
    do_reset();
    check1("reset_duty", intf.duty_out, '0);
    check1("reset_flags", {{(N*DW-2){1'b0}}, intf.busy, intf.done}, '0);
    tick(0, 0, '1, 0, 0, 0);
    do_reset();
    wcfg(0, 1, 2);
    wcfg(0, 4, 1000);
    wcfg(5, 1, 3);
    wcfg(5, 4, 1000);
    wcfg(8, 1, 50);
    wcfg(0, 7, 77);
    tick(100, -50, '1, 200, -150, 1);
    do_reset();
    wcfg(0, 1, 100);
    wcfg(0, 4, 500);
    tick(-100, 0, '1, -500, 0, 0);
    do_reset();
    wcfg(0, 2, 1);
    wcfg(0, 5, 250);
    wcfg(0, 4, 1000);
    for (int i = 0; i < 5; i++) tick(100, 0, '1, t4[i], 0, 0);
    tick(100, 0, 6'b111110, 0, 0, 0);
    tick(100, 0, '1, 100, 0, 0);
    do_reset();
    wcfg(0, 6, 10);
    wcfg(0, 1, 1);
    wcfg(0, 4, 1000);
    wcfg(0, 2, 1);
    wcfg(0, 5, 1000);
    tick(7, 0, '1, 0, 0, 0);
    tick(10, 0, '1, 0, 0, 0);
    tick(-10, 0, '1, 0, 0, 0);
    tick(20, 0, '1, 40, 0, 0);
    do_reset();
    wcfg(0, 3, 3);
    wcfg(0, 4, 1000);
    tick(10, 0, '1, D1, 0, 0);
    tick(30, 0, '1, D2, 0, 0);
    do_reset();
    wcfg(0, 1, 2);
    wcfg(0, 4, 1000);
    tick(100, 0, '1, 200, 0, 0);
    intf.state_in = vec(300, 0);
    intf.update = 1;
    @(posedge clk);
    #1 intf.update = 0;
    repeat (6) @(posedge clk);
    #1 reset = 1;
    #1 check1("abort_duty", intf.duty_out, '0);
    check1("abort_flags", {{(N*DW-2){1'b0}}, intf.busy, intf.done}, '0);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    repeat (4 * N + 4) @(posedge clk);
    #1 check1("abort_no_duty", intf.duty_out, '0);
    tick(100, 0, '1, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end
endmodule
